// File: rtl/ntt_add_pkg.sv
// Shared definitions for the modular-add scheduler: datapath width and FSM states.
package ntt_add_pkg;

  localparam int WIDTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RED  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/CLA_Adder.sv
// Two-level carry-lookahead adder without carry-in.
// Bits are grouped in fours. Each group forms generate/propagate terms.
// Groups are gathered in fours into 16-bit super-groups, and the carry
// between super-groups ripples. WIDTH must be a multiple of 16.
module CLA_Adder #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int NG = WIDTH / 4;
  localparam int NS = NG / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;

  assign g     = A & B;
  assign p     = A ^ B;
  assign gc[0] = 1'b0;

  // Per-group generate/propagate and in-group bit carries from the group carry-in.
  for (genvar j = 0; j < NG; j++) begin : g_grp
    localparam int BB = 4 * j;
    assign gg[j] = g[BB+3] | (p[BB+3] & g[BB+2]) | (p[BB+3] & p[BB+2] & g[BB+1])
                 | (p[BB+3] & p[BB+2] & p[BB+1] & g[BB]);
    assign gp[j] = &p[BB+3:BB];

    assign c[BB]   = gc[j];
    assign c[BB+1] = g[BB] | (p[BB] & gc[j]);
    assign c[BB+2] = g[BB+1] | (p[BB+1] & g[BB]) | (p[BB+1] & p[BB] & gc[j]);
    assign c[BB+3] = g[BB+2] | (p[BB+2] & g[BB+1]) | (p[BB+2] & p[BB+1] & g[BB])
                   | (p[BB+2] & p[BB+1] & p[BB] & gc[j]);
  end

  // Group carries inside each super-group are looked ahead from the super-group carry-in.
  for (genvar s = 0; s < NS; s++) begin : g_super
    localparam int X = 4 * s;
    logic sc;
    assign sc      = gc[X];
    assign gc[X+1] = gg[X] | (gp[X] & sc);
    assign gc[X+2] = gg[X+1] | (gp[X+1] & gg[X]) | (gp[X+1] & gp[X] & sc);
    assign gc[X+3] = gg[X+2] | (gp[X+2] & gg[X+1]) | (gp[X+2] & gp[X+1] & gg[X])
                   | (gp[X+2] & gp[X+1] & gp[X] & sc);
    assign gc[X+4] = gg[X+3] | (gp[X+3] & gg[X+2]) | (gp[X+3] & gp[X+2] & gg[X+1])
                   | (gp[X+3] & gp[X+2] & gp[X+1] & gg[X]) | ((&gp[X+3:X]) & sc);
  end

  assign Sum  = p ^ c;
  assign Cout = gc[NG];

endmodule

// File: rtl/mod_add_scheduler.sv
// Modular adder r = (a + b) mod q for two requesters, sharing one CLA.
// Each operation takes two adder passes: first the raw sum, then sum + (2^W - q).
// The reduced value is chosen from the two carries.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A requester keeps valid and its operands stable until it sees
// ready, and never withdraws valid. The response side holds rsp_valid,
// rsp_id and rsp_data stable until rsp_ready is seen.
module mod_add_scheduler
  import ntt_add_pkg::*;
#(
  parameter int WIDTH = ntt_add_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [WIDTH-1:0] neg_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] nq_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] res_q;
  logic             cs_q;
  logic             id_q;
  logic             last_grant;

  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid == 2'b11) grant_id = ~last_grant;
    else                    grant_id = req_valid[1];
  end

  assign req_ready[0] = (state == ST_IDLE) & req_valid[0] & ~grant_id;
  assign req_ready[1] = (state == ST_IDLE) & req_valid[1] &  grant_id;
  assign accept       = |req_ready;

  // The shared adder sees the operands in ADD and (s, neg_q) in RED.
  assign add_a = (state == ST_RED) ? s_q  : a_q;
  assign add_b = (state == ST_RED) ? nq_q : b_q;

  CLA_Adder #(.WIDTH(WIDTH)) u_cla (
    .A    (add_a),
    .B    (add_b),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: one cycle each in ADD and RED, then wait in OUT for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_ADD;
      ST_ADD:  state_nxt = ST_RED;
      ST_RED:  state_nxt = ST_OUT;
      ST_OUT:  if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture on accept, first-pass sum in ADD, reduced result in RED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      nq_q       <= '0;
      s_q        <= '0;
      res_q      <= '0;
      cs_q       <= 1'b0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q        <= grant_id ? req_a1 : req_a0;
            b_q        <= grant_id ? req_b1 : req_b0;
            nq_q       <= neg_q;
            id_q       <= grant_id;
            last_grant <= grant_id;
          end
        end
        ST_ADD: begin
          s_q  <= add_sum;
          cs_q <= add_cout;
        end
        ST_RED: begin
          // Either carry means the sum reached q, so the subtracted value is the answer.
          res_q <= (cs_q | add_cout) ? add_sum : s_q;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == ST_OUT);
  assign rsp_id    = id_q;
  assign rsp_data  = res_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mod_add_scheduler.sv
// Bench for mod_add_scheduler: queued requests per requester, a reference
// modular adder feeding an expected queue, and checks on grant order, latency,
// backpressure and reset behaviour.
module tb_mod_add_scheduler;

  localparam int WIDTH = 128;
  localparam int CW    = WIDTH + 1;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [WIDTH-1:0] neg_q;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  mod_add_scheduler #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .neg_q     (neg_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [WIDTH:0]   exp_q[$];      // {id, data}
  logic [WIDTH-1:0] qa0[$];
  logic [WIDTH-1:0] qb0[$];
  logic [WIDTH-1:0] qa1[$];
  logic [WIDTH-1:0] qb1[$];
  logic             grant_log[$];
  logic             tb_last;
  logic             rsp_seen;
  int               cyc;
  int               acc_cyc;
  int               n_chk;
  int               n_pass;

  task automatic check(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: q = 2^W - neg_q, result = a + b reduced once by q.
  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] nq);
    logic [WIDTH:0] q;
    logic [WIDTH:0] sum;
    q   = {1'b1, {WIDTH{1'b0}}} - {1'b0, nq};
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= q) sum = sum - q;
    return sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] negq_of(input logic [WIDTH-1:0] q);
    return {WIDTH{1'b0}} - q;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load(input logic g);
    if (!g) begin
      if (qa0.size() > 0) begin req_a0 = qa0[0]; req_b0 = qb0[0]; req_valid[0] = 1'b1; end
      else req_valid[0] = 1'b0;
    end else begin
      if (qa1.size() > 0) begin req_a1 = qa1[0]; req_b1 = qb1[0]; req_valid[1] = 1'b1; end
      else req_valid[1] = 1'b0;
    end
  endtask

  task automatic send(input logic g, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (!g) begin qa0.push_back(a); qb0.push_back(b); end
    else    begin qa1.push_back(a); qb1.push_back(b); end
    if (!req_valid[g]) load(g);
  endtask

  // One clock: observe at the falling edge, update drivers just after the rising edge.
  task automatic step();
    logic [1:0]       acc;
    logic             g;
    logic             exp_g;
    logic [WIDTH-1:0] oa;
    logic [WIDTH-1:0] ob;
    logic [WIDTH:0]   e;
    @(negedge clk);
    cyc++;
    acc = 2'b00;
    if (!rst) begin
      if (rsp_valid) begin
        if (!rsp_seen) begin
          check("latency", CW'(cyc - acc_cyc), CW'(3));
          rsp_seen = 1'b1;
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) check("unexpected_rsp", CW'(rsp_valid), CW'(0));
          else begin
            e = exp_q.pop_front();
            check("rsp_id", CW'(rsp_id), CW'(e[WIDTH]));
            check("rsp_data", CW'(rsp_data), CW'(e[WIDTH-1:0]));
          end
          rsp_seen = 1'b0;
        end
      end
      acc = req_valid & req_ready;
      if (acc != 2'b00) begin
        if (req_valid == 2'b11) check("ready_onehot", CW'(req_ready == 2'b11), CW'(0));
        g     = acc[1];
        exp_g = (req_valid == 2'b11) ? ~tb_last : req_valid[1];
        check("grant", CW'(g), CW'(exp_g));
        tb_last = g;
        grant_log.push_back(g);
        oa = g ? req_a1 : req_a0;
        ob = g ? req_b1 : req_b0;
        exp_q.push_back({g, mod_add(oa, ob, neg_q)});
        acc_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    if (acc[0]) begin void'(qa0.pop_front()); void'(qb0.pop_front()); load(1'b0); end
    if (acc[1]) begin void'(qa1.pop_front()); void'(qb1.pop_front()); load(1'b1); end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(!busy && exp_q.size() == 0 && req_valid == 2'b00) && n < budget) begin
      step();
      n++;
    end
    check("drain", CW'(!busy && exp_q.size() == 0 && req_valid == 2'b00), CW'(1));
  endtask

  task automatic wait_busy(input int budget);
    int n;
    n = 0;
    while (!busy && n < budget) begin
      step();
      n++;
    end
    check("accept_seen", CW'(busy), CW'(1));
  endtask

  task automatic clear_sb();
    exp_q.delete();
    qa0.delete(); qb0.delete(); qa1.delete(); qb1.delete();
    tb_last  = 1'b1;
    rsp_seen = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WIDTH-1:0] q_big;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    n_chk = 0; n_pass = 0; cyc = 0; acc_cyc = 0;
    tb_last = 1'b1; rsp_seen = 1'b0;
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    neg_q = negq_of(WIDTH'(17));

    // Reset values.
    @(negedge clk);
    check("rst_rsp_valid", CW'(rsp_valid), CW'(0));
    check("rst_rsp_id",    CW'(rsp_id),    CW'(0));
    check("rst_rsp_data",  CW'(rsp_data),  CW'(0));
    check("rst_busy",      CW'(busy),      CW'(0));
    check("rst_req_ready", CW'(req_ready), CW'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request, q = 17: 10 + 9 -> 2.
    send(1'b0, WIDTH'(10), WIDTH'(9));
    wait_idle(20);

    // Boundaries with q = 17, back to back on both requesters.
    send(1'b0, WIDTH'(16), WIDTH'(1));
    send(1'b0, WIDTH'(0),  WIDTH'(0));
    send(1'b1, WIDTH'(3),  WIDTH'(4));
    send(1'b1, WIDTH'(16), WIDTH'(16));
    wait_idle(60);

    // Carry out of the first pass: q = 2^W - 159, a = b = q - 1.
    neg_q = WIDTH'(159);
    q_big = negq_of(WIDTH'(159));
    send(1'b0, q_big - WIDTH'(1), q_big - WIDTH'(1));
    send(1'b1, q_big - WIDTH'(1), WIDTH'(0));
    wait_idle(40);

    // neg_q changes after accept: the in-flight op keeps q = 17.
    neg_q = negq_of(WIDTH'(17));
    send(1'b1, WIDTH'(12), WIDTH'(9));
    wait_busy(10);
    neg_q = WIDTH'(159);
    wait_idle(20);
    neg_q = negq_of(WIDTH'(17));

    // Contention from reset: both held valid, grants alternate starting with 0.
    rst = 1'b1;
    clear_sb();
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, WIDTH'($urandom_range(0, 16)), WIDTH'($urandom_range(0, 16)));
      send(1'b1, WIDTH'($urandom_range(0, 16)), WIDTH'($urandom_range(0, 16)));
    end
    grant_log.delete();
    step(); step();
    rst = 1'b0;
    wait_idle(100);
    check("cont_count", CW'(grant_log.size()), CW'(8));
    for (int i = 0; i < grant_log.size(); i++)
      check("cont_order", CW'(grant_log[i]), CW'(i % 2));

    // Random wide operands with large q.
    neg_q = WIDTH'(159);
    for (int i = 0; i < 3; i++) begin
      ra = {1'b0, 31'($urandom), $urandom, $urandom, $urandom};
      rb = {1'b0, 31'($urandom), $urandom, $urandom, $urandom};
      send(1'(i % 2), ra, rb);
    end
    wait_idle(60);
    neg_q = negq_of(WIDTH'(17));

    // Backpressure: hold rsp_ready low 5 cycles in OUT with another request pending.
    rsp_ready = 1'b0;
    send(1'b1, WIDTH'(7), WIDTH'(8));
    send(1'b0, WIDTH'(1), WIDTH'(1));
    for (int n = 0; n < 20 && !rsp_valid; n++) step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", CW'(rsp_valid), CW'(1));
      check("bp_ready", CW'(req_ready), CW'(0));
      check("bp_busy",  CW'(busy),      CW'(1));
      if (exp_q.size() > 0) begin
        check("bp_data", CW'(rsp_data), CW'(exp_q[0][WIDTH-1:0]));
        check("bp_id",   CW'(rsp_id),   CW'(exp_q[0][WIDTH]));
      end else check("bp_expect", CW'(exp_q.size()), CW'(1));
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_idle", CW'(busy), CW'(0));
    wait_idle(20);

    // Reset during RED: outputs clear at once and the op is dropped.
    send(1'b1, WIDTH'(1), WIDTH'(2));
    wait_busy(10);
    step();
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    check("mid_rsp_valid", CW'(rsp_valid), CW'(0));
    check("mid_rsp_id",    CW'(rsp_id),    CW'(0));
    check("mid_rsp_data",  CW'(rsp_data),  CW'(0));
    check("mid_busy",      CW'(busy),      CW'(0));
    check("mid_req_ready", CW'(req_ready), CW'(0));
    clear_sb();
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mid_no_rsp", CW'(rsp_valid), CW'(0));
    grant_log.delete();
    send(1'b0, WIDTH'(5), WIDTH'(5));
    wait_idle(20);
    check("post_grant_cnt", CW'(grant_log.size()), CW'(1));
    if (grant_log.size() > 0) check("post_grant", CW'(grant_log[0]), CW'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute time bound in case a wait loop is broken.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
